// File: rtl/regfile_io_pkg.sv
// Shared defaults and address-map legality check for the picoMIPS register file.
package regfile_io_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_NUM_OUT    = 1;
  localparam int DEF_OUT_BASE   = 1;
  localparam int DEF_IN_ADDR    = 2**DEF_ADDR_WIDTH - 1;
  localparam int DEF_STAT_ADDR  = 2**DEF_ADDR_WIDTH - 2;

  // True when IN/STAT are distinct, outside the output window, and everything fits.
  function automatic bit map_ok(input int aw, input int num_out, input int out_base,
                                input int in_addr, input int stat_addr);
    int depth;
    int out_last;
    bit ok;
    depth    = 2**aw;
    out_last = out_base + num_out - 1;
    ok       = 1'b1;
    if (num_out < 1 || num_out > depth - 2) ok = 1'b0;
    if (out_base < 0 || out_last > depth - 1) ok = 1'b0;
    if (in_addr < 0 || in_addr > depth - 1) ok = 1'b0;
    if (stat_addr < 0 || stat_addr > depth - 1) ok = 1'b0;
    if (in_addr == stat_addr) ok = 1'b0;
    if (in_addr >= out_base && in_addr <= out_last) ok = 1'b0;
    if (stat_addr >= out_base && stat_addr <= out_last) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/regfile_io_input_sync.sv
// Two-flop synchroniser for the external input plus a sticky change flag.
module input_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ext_in,
  input  logic             clr,
  output logic [WIDTH-1:0] in_sync,
  output logic             in_changed
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_prev;
  logic             r_changed;
  logic             w_set;

  assign w_set = (r_sync != r_prev);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta    <= '0;
      r_sync    <= '0;
      r_prev    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_meta <= ext_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
      // A change detected on the same edge as a software clear must not be lost.
      if (w_set)
        r_changed <= 1'b1;
      else if (clr)
        r_changed <= 1'b0;
    end
  end

  assign in_sync    = r_sync;
  assign in_changed = r_changed;

endmodule

// File: rtl/regfile_io.sv
// Register file with output shadow registers, a synchronised input and a sticky status bit.
module regfile_io
  import regfile_io_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_OUT    = DEF_NUM_OUT,
  parameter int OUT_BASE   = DEF_OUT_BASE,
  parameter int IN_ADDR    = 2**ADDR_WIDTH - 1,
  parameter int STAT_ADDR  = 2**ADDR_WIDTH - 2,
  parameter int BYPASS     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [ADDR_WIDTH-1:0]         rd_addr1,
  input  logic [ADDR_WIDTH-1:0]         rd_addr2,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic [DATA_WIDTH-1:0]         ext_in,
  output logic [DATA_WIDTH-1:0]         rd_data1,
  output logic [DATA_WIDTH-1:0]         rd_data2,
  output logic [NUM_OUT*DATA_WIDTH-1:0] out_ports,
  output logic                          in_changed
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] IN_A   = ADDR_WIDTH'(IN_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STAT_A = ADDR_WIDTH'(STAT_ADDR);

  if (!map_ok(ADDR_WIDTH, NUM_OUT, OUT_BASE, IN_ADDR, STAT_ADDR)) begin : g_map_check
    $fatal(1, "regfile_io: illegal address map");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_out [NUM_OUT];
  logic [DATA_WIDTH-1:0] w_in_sync;
  logic [DATA_WIDTH-1:0] w_stat_word;
  logic                  w_in_changed;
  logic                  w_stat_clr;
  logic                  w_byp1;
  logic                  w_byp2;

  assign w_stat_clr  = we && (wr_addr == STAT_A);
  assign w_stat_word = DATA_WIDTH'(w_in_changed);

  input_sync #(.WIDTH(DATA_WIDTH)) u_input_sync (
    .clk        (clk),
    .rst        (rst),
    .ext_in     (ext_in),
    .clr        (w_stat_clr),
    .in_sync    (w_in_sync),
    .in_changed (w_in_changed)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      for (int i = 0; i < NUM_OUT; i++) r_out[i] <= '0;
    end else if (we) begin
      r_mem[wr_addr] <= wr_data;
      for (int i = 0; i < NUM_OUT; i++)
        if (wr_addr == ADDR_WIDTH'(OUT_BASE + i)) r_out[i] <= wr_data;
    end
  end

  assign w_byp1 = (BYPASS != 0) && we && (rd_addr1 == wr_addr);
  assign w_byp2 = (BYPASS != 0) && we && (rd_addr2 == wr_addr);

  // Mapped IN/STAT addresses always win over bypass and storage.
  always_comb begin
    rd_data1 = r_mem[rd_addr1];
    if (rd_addr1 == IN_A)        rd_data1 = w_in_sync;
    else if (rd_addr1 == STAT_A) rd_data1 = w_stat_word;
    else if (w_byp1)             rd_data1 = wr_data;
  end

  always_comb begin
    rd_data2 = r_mem[rd_addr2];
    if (rd_addr2 == IN_A)        rd_data2 = w_in_sync;
    else if (rd_addr2 == STAT_A) rd_data2 = w_stat_word;
    else if (w_byp2)             rd_data2 = wr_data;
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_ports[g*DATA_WIDTH +: DATA_WIDTH] = r_out[g];
  end

  assign in_changed = w_in_changed;

endmodule

// File: tb/tb_regfile_io.sv
// Bench for regfile_io: directed scenarios plus randomized traffic against a history-based model.
module tb_regfile_io;

  logic        clk;
  logic        rst;
  logic        we;
  logic [2:0]  rd_addr1, rd_addr2, wr_addr;
  logic [7:0]  wr_data, ext_in;
  logic [7:0]  rd1_a, rd2_a, rd1_b, rd2_b;
  logic [15:0] outp_a;
  logic [7:0]  outp_b;
  logic        chg_a, chg_b;

  int checks = 0;
  int errors = 0;

  // Model: storage contents, sticky flag and the ext_in value sampled at every edge since reset.
  logic [7:0] m_mem [8];
  logic       m_changed;
  logic [7:0] samp_q[$];

  regfile_io #(.NUM_OUT(2), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .we(we), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .wr_addr(wr_addr), .wr_data(wr_data), .ext_in(ext_in),
    .rd_data1(rd1_a), .rd_data2(rd2_a), .out_ports(outp_a), .in_changed(chg_a)
  );

  regfile_io #(.NUM_OUT(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .wr_addr(wr_addr), .wr_data(wr_data), .ext_in(ext_in),
    .rd_data1(rd1_b), .rd_data2(rd2_b), .out_ports(outp_b), .in_changed(chg_b)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Sample taken at edge j (1-based since reset); zero before any sample exists.
  function automatic logic [7:0] s_at(input int j);
    if (j < 1 || j > samp_q.size()) return 8'h00;
    return samp_q[j-1];
  endfunction

  function automatic logic [7:0] exp_read(input logic [2:0] a, input bit byp);
    int n;
    n = samp_q.size();
    if (a == 3'd7) return s_at(n - 1);
    if (a == 3'd6) return {7'b0, m_changed};
    if (byp && we && a == wr_addr) return wr_data;
    return m_mem[a];
  endfunction

  task automatic model_update();
    int  n;
    bit  set;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
      m_changed = 1'b0;
      samp_q.delete();
    end else begin
      samp_q.push_back(ext_in);
      n   = samp_q.size();
      set = (s_at(n - 2) != s_at(n - 3));
      if (set) m_changed = 1'b1;
      else if (we && wr_addr == 3'd6) m_changed = 1'b0;
      if (we) m_mem[wr_addr] = wr_data;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [2:0] a,
                       input logic [7:0] d, input logic [7:0] x);
    rst = r; we = w; wr_addr = a; wr_data = d; ext_in = x;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 3'd0, 8'h00, 8'h00);
    tick();
    tick();
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
  endtask

  task automatic test_reset();
    do_reset();
    for (int a = 0; a < 8; a++) begin
      rd_addr1 = 3'(a);
      rd_addr2 = 3'(7 - a);
      #1;
      checks++;
      if (a != 7 && rd1_a !== 8'h00) begin
        errors++; $display("FAIL reset_rd1 addr %0d got %h exp 00", a, rd1_a);
      end
      checks++;
      if ((7 - a) != 7 && rd2_b !== 8'h00) begin
        errors++; $display("FAIL reset_rd2 addr %0d got %h exp 00", 7 - a, rd2_b);
      end
    end
    checks++;
    if (outp_a !== 16'h0000 || outp_b !== 8'h00) begin
      errors++; $display("FAIL reset_out got %h/%h exp 0000/00", outp_a, outp_b);
    end
    checks++;
    if (chg_a !== 1'b0 || chg_b !== 1'b0) begin
      errors++; $display("FAIL reset_chg got %b/%b exp 0/0", chg_a, chg_b);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    drive(1'b0, 1'b1, 3'd3, 8'hA5, 8'h00);
    rd_addr1 = 3'd3;
    #1;
    checks++;
    if (rd1_a !== 8'hA5) begin
      errors++; $display("FAIL bypass_same_cycle got %h exp a5", rd1_a);
    end
    checks++;
    if (rd1_b !== 8'h00) begin
      errors++; $display("FAIL nobypass_same_cycle got %h exp 00", rd1_b);
    end
    tick();
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    #1;
    checks++;
    if (rd1_a !== 8'hA5 || rd1_b !== 8'hA5) begin
      errors++; $display("FAIL write_after got %h/%h exp a5/a5", rd1_a, rd1_b);
    end
  endtask

  task automatic test_out_ports();
    do_reset();
    drive(1'b0, 1'b1, 3'd1, 8'h11, 8'h00);
    tick();
    drive(1'b0, 1'b1, 3'd2, 8'h3C, 8'h00);
    tick();
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    rd_addr1 = 3'd2;
    rd_addr2 = 3'd1;
    #1;
    checks++;
    if (outp_a !== 16'h3C11) begin
      errors++; $display("FAIL out_ports2 got %h exp 3c11", outp_a);
    end
    checks++;
    if (outp_b !== 8'h11) begin
      errors++; $display("FAIL out_ports1 got %h exp 11", outp_b);
    end
    checks++;
    if (rd1_a !== 8'h3C || rd2_a !== 8'h11) begin
      errors++; $display("FAIL out_readback got %h/%h exp 3c/11", rd1_a, rd2_a);
    end
  endtask

  task automatic test_input_change();
    do_reset();
    tick(); tick(); tick();
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h5A);
    rd_addr1 = 3'd7;
    rd_addr2 = 3'd6;
    tick();
    checks++;
    if (rd1_a !== 8'h00 || chg_a !== 1'b0) begin
      errors++; $display("FAIL in_edge_k got %h/%b exp 00/0", rd1_a, chg_a);
    end
    tick();
    checks++;
    if (rd1_a !== 8'h5A || rd1_b !== 8'h5A || chg_a !== 1'b0) begin
      errors++; $display("FAIL in_edge_k1 got %h/%h/%b exp 5a/5a/0", rd1_a, rd1_b, chg_a);
    end
    tick();
    checks++;
    if (chg_a !== 1'b1 || chg_b !== 1'b1 || rd2_a !== 8'h01) begin
      errors++; $display("FAIL in_edge_k2 got %b/%b/%h exp 1/1/01", chg_a, chg_b, rd2_a);
    end
  endtask

  task automatic test_stat_clear();
    drive(1'b0, 1'b1, 3'd6, 8'h00, 8'h5A);
    tick();
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'hC3);
    checks++;
    if (chg_a !== 1'b0) begin
      errors++; $display("FAIL plain_clear got %b exp 0", chg_a);
    end
    tick();
    tick();
    drive(1'b0, 1'b1, 3'd6, 8'h00, 8'hC3);
    tick();
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'hC3);
    checks++;
    if (chg_a !== 1'b1 || chg_b !== 1'b1) begin
      errors++; $display("FAIL set_wins got %b/%b exp 1/1", chg_a, chg_b);
    end
    drive(1'b0, 1'b1, 3'd6, 8'h00, 8'hC3);
    tick();
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'hC3);
    checks++;
    if (chg_a !== 1'b0) begin
      errors++; $display("FAIL clear_after_set got %b exp 0", chg_a);
    end
  endtask

  task automatic test_reset_write();
    drive(1'b0, 1'b1, 3'd1, 8'h22, 8'h00);
    tick();
    drive(1'b1, 1'b1, 3'd1, 8'hFF, 8'h00);
    tick();
    drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    rd_addr1 = 3'd1;
    #1;
    checks++;
    if (outp_a !== 16'h0000 || outp_b !== 8'h00) begin
      errors++; $display("FAIL rst_wins_out got %h/%h exp 0000/00", outp_a, outp_b);
    end
    checks++;
    if (rd1_a !== 8'h00 || rd1_b !== 8'h00) begin
      errors++; $display("FAIL rst_wins_entry got %h/%h exp 00/00", rd1_a, rd1_b);
    end
  endtask

  task automatic test_random();
    logic [7:0] cur_x;
    logic [7:0] e;
    cur_x = 8'h00;
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 5) == 0) cur_x = 8'($urandom);
      drive(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 8'($urandom), cur_x);
      rd_addr1 = 3'($urandom_range(0, 7));
      rd_addr2 = 3'($urandom_range(0, 7));
      #1;
      e = exp_read(rd_addr1, 1'b1);
      checks++;
      if (rd1_a !== e) begin
        errors++; $display("FAIL rand_rd1_byp it %0d addr %0d got %h exp %h", it, rd_addr1, rd1_a, e);
      end
      e = exp_read(rd_addr2, 1'b1);
      checks++;
      if (rd2_a !== e) begin
        errors++; $display("FAIL rand_rd2_byp it %0d addr %0d got %h exp %h", it, rd_addr2, rd2_a, e);
      end
      e = exp_read(rd_addr1, 1'b0);
      checks++;
      if (rd1_b !== e) begin
        errors++; $display("FAIL rand_rd1_nobyp it %0d addr %0d got %h exp %h", it, rd_addr1, rd1_b, e);
      end
      e = exp_read(rd_addr2, 1'b0);
      checks++;
      if (rd2_b !== e) begin
        errors++; $display("FAIL rand_rd2_nobyp it %0d addr %0d got %h exp %h", it, rd_addr2, rd2_b, e);
      end
      checks++;
      if (outp_a !== {m_mem[2], m_mem[1]} || outp_b !== m_mem[1]) begin
        errors++; $display("FAIL rand_out it %0d got %h/%h exp %h%h/%h", it, outp_a, outp_b,
                           m_mem[2], m_mem[1], m_mem[1]);
      end
      checks++;
      if (chg_a !== m_changed || chg_b !== m_changed) begin
        errors++; $display("FAIL rand_chg it %0d got %b/%b exp %b", it, chg_a, chg_b, m_changed);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
    wr_addr = '0; wr_data = '0; ext_in = '0;
    m_changed = 1'b0;
    for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
    test_reset();
    test_bypass();
    test_out_ports();
    test_input_change();
    test_stat_clear();
    test_reset_write();
    do_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
